// File: rtl/mavg_pkg.sv
// Shared widths and the stage-1 pipeline record for the multi-channel moving-average filter.
package mavg_pkg;

  // Stage-1 record is sized for the widest supported configuration.
  localparam int STAGE_DATA_MAX = 32;
  localparam int STAGE_CH_MAX   = 4;

  function automatic int acc_width(input int data_width, input int max_wind_width);
    return data_width + max_wind_width;
  endfunction

  function automatic int ch_width(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

  typedef struct packed {
    logic [STAGE_DATA_MAX-1:0] data;
    logic [STAGE_CH_MAX-1:0]   ch;
    logic                      full;   // slot being overwritten held a live sample
    logic                      emit;   // window complete after this write
    logic                      valid;
  } stage1_t;

endpackage

// File: rtl/mavg_sample_ram.sv
// Single-port, read-first sample store; the read port updates only when enabled.
module mavg_sample_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 128,
  parameter int ADDR_W     = 7
) (
  input  logic                  clk,
  input  logic                  ce,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (ce) begin
      rdata <= mem[addr];
      if (we) mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/mavg_filter_mc.sv
// Time-multiplexed per-channel moving average over a 2^w window with a 2-cycle,
// globally stalled pipeline: accept/RAM -> accumulate -> round, shift and present.
module mavg_filter_mc
  import mavg_pkg::*;
#(
  parameter int  NUM_CH         = 4,
  parameter int  DATA_WIDTH     = 16,
  parameter int  MAX_WIND_WIDTH = 5,
  parameter int  SIGNED         = 0,
  localparam int CH_W           = ch_width(NUM_CH),
  localparam int WS_W           = $clog2(MAX_WIND_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [WS_W-1:0]       wind_sel,
  input  logic                  round_en,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [CH_W-1:0]       s_ch,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CH_W-1:0]       m_ch,
  output logic                  err_ch
);

  localparam int ACC_W  = acc_width(DATA_WIDTH, MAX_WIND_WIDTH);
  localparam int PTR_W  = MAX_WIND_WIDTH;
  localparam int FILL_W = MAX_WIND_WIDTH + 1;
  localparam int DEPTH  = NUM_CH << PTR_W;
  localparam int RAM_AW = $clog2(DEPTH);

  function automatic logic [WS_W-1:0] clamp_w(input logic [WS_W-1:0] w);
    if (int'(w) > MAX_WIND_WIDTH) return WS_W'(MAX_WIND_WIDTH);
    return w;
  endfunction

  function automatic logic [ACC_W-1:0] extend(input logic [DATA_WIDTH-1:0] x);
    if (SIGNED != 0) return ACC_W'($signed(x));
    return ACC_W'(x);
  endfunction

  // One guard bit keeps the rounding offset from wrapping a full-scale sum.
  function automatic logic [DATA_WIDTH-1:0] average(input logic [ACC_W-1:0] a,
                                                    input logic [WS_W-1:0]  w,
                                                    input logic             rnd);
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] res;
    sum = (SIGNED != 0) ? {a[ACC_W-1], a} : {1'b0, a};
    if (rnd && w != '0) sum = sum + ((ACC_W+1)'(1) << (w - 1'b1));
    if (SIGNED != 0) res = sum >>> w;
    else             res = $signed($unsigned(sum) >> w);
    return res[DATA_WIDTH-1:0];
  endfunction

  logic [WS_W-1:0]       w_q;
  logic [PTR_W-1:0]      ptr_q  [NUM_CH];
  logic [FILL_W-1:0]     fill_q [NUM_CH];
  logic [ACC_W-1:0]      acc_q  [NUM_CH];

  stage1_t               s1_p1;
  logic [ACC_W-1:0]      acc_p2;
  logic [CH_W-1:0]       ch_p2;
  logic                  vld_p2;

  logic                  en, accept, ch_ok, wr;
  logic [FILL_W-1:0]     win_size;
  logic [PTR_W-1:0]      ptr_mask;
  logic [PTR_W-1:0]      cur_ptr;
  logic [FILL_W-1:0]     cur_fill;
  logic [ACC_W-1:0]      cur_acc, acc_new;
  logic [DATA_WIDTH-1:0] old_data;
  logic                  unused_p1;

  assign en       = !m_valid || m_ready;
  assign s_ready  = en && !clear;
  assign ch_ok    = int'(s_ch) < NUM_CH;
  assign accept   = s_valid && s_ready && !reset;
  assign wr       = accept && ch_ok;
  assign win_size = FILL_W'(1) << w_q;
  assign ptr_mask = PTR_W'(win_size - 1'b1);
  assign unused_p1 = ^s1_p1;

  always_comb begin
    cur_ptr  = '0;
    cur_fill = '0;
    cur_acc  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (s_ch == CH_W'(i)) begin
        cur_ptr  = ptr_q[i];
        cur_fill = fill_q[i];
      end
      if (s1_p1.ch[CH_W-1:0] == CH_W'(i)) cur_acc = acc_q[i];
    end
    acc_new = cur_acc + extend(s1_p1.data[DATA_WIDTH-1:0])
            - (s1_p1.full ? extend(old_data) : '0);
  end

  mavg_sample_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .ce    (wr),
    .we    (wr),
    .addr  (RAM_AW'({s_ch, cur_ptr})),
    .wdata (s_data),
    .rdata (old_data)
  );

  // Stage 0: per-channel pointer/fill bookkeeping at accept; accumulators retire in stage 2.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      w_q <= clamp_w(wind_sel);
      for (int i = 0; i < NUM_CH; i++) begin
        ptr_q[i]  <= '0;
        fill_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr && s_ch == CH_W'(i)) begin
          ptr_q[i] <= (ptr_q[i] + 1'b1) & ptr_mask;
          if (fill_q[i] < win_size) fill_q[i] <= fill_q[i] + 1'b1;
        end
        if (en && s1_p1.valid && s1_p1.ch[CH_W-1:0] == CH_W'(i)) acc_q[i] <= acc_new;
      end
    end
  end

  // Stage 1: accepted sample plus the fill state seen at accept.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      s1_p1.valid <= 1'b0;
    end else if (en) begin
      s1_p1.valid <= wr;
      s1_p1.data  <= STAGE_DATA_MAX'(s_data);
      s1_p1.ch    <= STAGE_CH_MAX'(s_ch);
      s1_p1.full  <= (cur_fill == win_size);
      s1_p1.emit  <= (cur_fill + 1'b1 >= win_size);
    end
  end

  // Stage 2: updated window sum.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      vld_p2 <= 1'b0;
    end else if (en) begin
      vld_p2 <= s1_p1.valid && s1_p1.emit;
      acc_p2 <= acc_new;
      ch_p2  <= s1_p1.ch[CH_W-1:0];
    end
  end

  // Output stage: round, divide by the window and present.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ch    <= '0;
    end else if (clear) begin
      m_valid <= 1'b0;
    end else if (en) begin
      m_valid <= vld_p2;
      m_data  <= average(acc_p2, w_q, round_en);
      m_ch    <= ch_p2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear)     err_ch <= 1'b0;
    else if (accept && !ch_ok) err_ch <= 1'b1;
  end

endmodule

// File: tb/tb_mavg_filter_mc.sv
// Scoreboard bench for mavg_filter_mc: a window-queue reference model predicts each
// averaged output at accept time; an independent monitor checks what the DUT presents.
module tb_mavg_filter_mc;

  localparam int NUM_CH = 3;
  localparam int DW     = 16;
  localparam int MWW    = 5;
  localparam int CW     = 2;
  localparam int WSW    = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          round_en = 1'b0;
  logic [WSW-1:0] wind_sel = 3'd2;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic [CW-1:0] s_ch = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic [CW-1:0] m_ch;
  logic          err_ch;

  always #5 clk = ~clk;

  mavg_filter_mc #(
    .NUM_CH         (NUM_CH),
    .DATA_WIDTH     (DW),
    .MAX_WIND_WIDTH (MWW),
    .SIGNED         (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .wind_sel (wind_sel),
    .round_en (round_en),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_ch     (s_ch),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_ch     (m_ch),
    .err_ch   (err_ch)
  );

  typedef struct { int ch; int data; } exp_t;

  exp_t exp_q[$];
  int   win_q[NUM_CH][$];
  int   w_m = 0;
  bit   err_exp = 1'b0;
  bit   rand_rdy = 1'b0;
  int   total = 0;
  int   bad = 0;

  function automatic void check(string name, longint act, longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endfunction

  function automatic void model_flush();
    for (int c = 0; c < NUM_CH; c++) win_q[c].delete();
    exp_q.delete();
    err_exp = 1'b0;
    w_m = (int'(wind_sel) > MWW) ? MWW : int'(wind_sel);
  endfunction

  // Average of the last 2^w samples of a channel, once it has 2^w of them.
  function automatic void model_accept(int ch, int d);
    longint sum, half;
    exp_t   e;
    int     n;
    n = 1 << w_m;
    if (ch >= NUM_CH) begin
      err_exp = 1'b1;
      return;
    end
    win_q[ch].push_back(d);
    if (win_q[ch].size() > n) void'(win_q[ch].pop_front());
    if (win_q[ch].size() < n) return;
    sum = 0;
    for (int k = 0; k < win_q[ch].size(); k++) sum += win_q[ch][k];
    half = (round_en && w_m > 0) ? (longint'(1) << (w_m - 1)) : 0;
    e.ch   = ch;
    e.data = int'((sum + half) >>> w_m);
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      check("s_ready", s_ready, (!m_valid || m_ready) && !clear);
      check("err_ch", err_ch, err_exp);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", longint'($signed(m_data)), -99999);
        end else begin
          e = exp_q.pop_front();
          check("m_data", longint'($signed(m_data)), e.data);
          check("m_ch", m_ch, e.ch);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) m_ready = ($urandom_range(0, 1) == 1);
  end

  task automatic send(input int ch, input int d);
    bit ok;
    int n;
    s_valid = 1'b1;
    s_ch    = CW'(ch);
    s_data  = DW'(d);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      n++;
    end
    if (!ok) check("send_timeout", n, -1);
    #1 s_valid = 1'b0;
    if (ok) model_accept(ch, d);
  endtask

  task automatic do_clear(input int w);
    wind_sel = WSW'(w);
    clear    = 1'b1;
    @(posedge clk);
    model_flush();
    #1 clear = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    model_flush();
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_ch", m_ch, 0);
    check("rst_err_ch", err_ch, 0);
    check("rst_s_ready", s_ready, 1);
    @(posedge clk);
    #1;

    // Single channel, window 4, truncating: 10 then 14, two clocks after accept.
    send(0, 4); send(0, 8); send(0, 12); send(0, 16);
    @(negedge clk); check("lat_edge1_m_valid", m_valid, 0);
    @(negedge clk); check("lat_edge2_m_valid", m_valid, 0);
    @(negedge clk); check("lat_edge3_m_valid", m_valid, 1);
    check("first_avg", longint'($signed(m_data)), 10);
    @(posedge clk); #1;
    send(0, 20);
    drain();

    // Two interleaved channels, window 2.
    do_clear(1);
    send(0, 10); send(1, 1); send(0, 20); send(1, 3); send(0, 30); send(1, 5);
    drain();

    // Signed rounding versus truncation.
    do_clear(1);
    round_en = 1'b1;
    send(2, -3); send(2, -2);
    drain();
    round_en = 1'b0;
    do_clear(1);
    send(2, -3); send(2, -2);
    drain();

    // Backpressure: 100 samples on channel 0, then mixed channels with a 32-deep window.
    do_clear(2);
    rand_rdy = 1'b1;
    for (int i = 0; i < 100; i++) send(0, int'($urandom_range(0, 65535)) - 32768);
    drain();
    do_clear(5);
    for (int i = 0; i < 240; i++) begin
      send(int'($urandom_range(0, NUM_CH - 1)), int'($urandom_range(0, 65535)) - 32768);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 m_ready = 1'b1;
    @(posedge clk); #1;

    // Window of one is a pass-through; then drop samples still in flight.
    do_clear(0);
    for (int i = 0; i < 8; i++) send(1, int'($urandom_range(0, 65535)) - 32768);
    drain();
    send(1, 5); send(1, 7);
    do_clear(3);
    send(0, 100); send(0, 100); send(0, 100);
    do_clear(1);
    send(0, 6); send(0, 8);
    drain();

    // Out-of-range channel: flagged, dropped, channel 0 unaffected.
    send(0, 40);
    send(3, 555);
    @(negedge clk);
    check("err_ch_set", err_ch, 1);
    @(posedge clk); #1;
    send(0, 60); send(0, 80);
    drain();
    do_clear(1);
    @(negedge clk);
    check("err_ch_cleared", err_ch, 0);
    @(posedge clk); #1;

    // Reset overrides a sample offered during reset.
    s_valid = 1'b1; s_ch = '0; s_data = DW'(9);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    model_flush();
    #1 reset = 1'b0;
    s_valid = 1'b0;
    send(0, 2); send(0, 4);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mavg_filter_mc.md
MAVG_FILTER_MC -- requirements
Module: mavg_filter_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of independent time-multiplexed channels (1..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning sample width.
REQ-003 SHALL have parameter MAX_WIND_WIDTH, default 5, meaning log2 of the largest window (max window 32).
REQ-004 SHALL have parameter SIGNED, default 0, meaning two's-complement samples when 1.
REQ-005 SHALL have port clk  in  1  rising-edge clock.
REQ-006 SHALL have port reset  in  1  reset; synchronous, active-high.
REQ-007 SHALL have port clear  in  1  single-cycle flush and window reload.
REQ-008 SHALL have port wind_sel  in  $clog2(MAX_WIND_WIDTH+1)  log2 of the window, sampled on reset/clear only.
REQ-009 SHALL have port round_en  in  1  round-half-up before the divide when 1; truncate when 0.
REQ-010 SHALL have ports s_valid in 1, s_ready out 1, s_data in DATA_WIDTH, s_ch in $clog2(NUM_CH) (min 1): input stream.
REQ-011 SHALL have ports m_valid out 1, m_ready in 1, m_data out DATA_WIDTH, m_ch out $clog2(NUM_CH) (min 1): output stream.
REQ-012 SHALL have port err_ch  out  1  sticky flag, set on acceptance of s_ch >= NUM_CH.

Function
REQ-013 Transfer SHALL occur on an edge where valid && ready; source data SHALL be held stable while valid && !ready.
REQ-014 Global pipeline enable en = !m_valid || m_ready; s_ready SHALL equal en && !clear.
REQ-015 Per channel SHALL keep: write pointer, fill counter (saturating at window W = 2^w), accumulator of DATA_WIDTH+MAX_WIND_WIDTH bits.
REQ-016 On accept: RAM[{ch,ptr}] written with s_data, old contents read (read-first), ptr = (ptr+1) mod W, fill++ if fill < W.
REQ-017 Stage 2 (next enabled edge): acc[ch] += x - (fill_was_full ? old : 0), using the fill state sampled at accept.
REQ-018 Output SHALL equal (acc_new + (round_en && w>0 ? 2^(w-1) : 0)) >> w; arithmetic shift when SIGNED; adder one bit wider than acc.
REQ-019 m_valid SHALL assert only for samples whose channel window was full after the write; earlier samples update state but produce no output.
REQ-020 Latency SHALL be 2 clk from the accepting edge to m_valid with m_ready held high; throughput 1 sample/clk, any channel order, back-to-back same channel included.
REQ-021 During stall (en=0) all pipeline registers, RAM output and m_* SHALL hold.
REQ-022 w = 0 SHALL pass samples through unchanged (m_data = s_data) with 2-clk latency.
REQ-023 Samples with s_ch >= NUM_CH SHALL be accepted, dropped without state change, and set err_ch.
REQ-024 clear SHALL have priority over everything: latch wind_sel, zero all ptr/fill/acc, drop in-flight samples, deassert m_valid next edge, clear err_ch; RAM contents need not be cleared.

Reset
REQ-025 reset SHALL act as clear plus: m_valid=0, m_data=0, m_ch=0, err_ch=0, s_ready=1 on the first edge after deassertion.
REQ-026 reset SHALL override in-progress transfers; no output generated from a sample accepted in the reset cycle.

Structure
REQ-027 Package mavg_pkg SHALL hold: acc width function, channel-id width function (min 1), stage-1 struct typedef (data, ch, full flag, valid).
REQ-028 One sub-module mavg_sample_ram SHALL implement the single-port, read-first, enable-gated sample store, depth NUM_CH*2^MAX_WIND_WIDTH, block-RAM inferable.

Verification
REQ-029 NUM_CH=1, w=2, truncate; feed 4,8,12,16,20 -> outputs only on 4th and 5th: 10, 14 at 2 clk latency.
REQ-030 NUM_CH=2, w=1, interleave ch0:10,20,30 ch1:1,3,5 -> ch0 15,25; ch1 2,4; m_ch tags match.
REQ-031 SIGNED=1, w=1, round_en=1; feed -3,-2 -> m_data=-2; round_en=0 -> -3.
REQ-032 Stream of 100 samples ch0, m_ready random 50% -> no loss/duplication, s_ready tracks !m_valid||m_ready, order preserved.
REQ-033 w=3 mid-stream clear, then w=1; feed 6,8 -> output 7, no stale sample from before clear contributes.
REQ-034 s_ch=NUM_CH -> err_ch=1, no output, channel 0 state unchanged; clear -> err_ch=0.
